// File: rtl/thrive_rst_pkg.sv
// -----------------------------------------------------------------------------
// thrive_rst_pkg
// Shared types and default sizing for the PE reset sequencer.
//   rst_seq_state_e   : sequencer FSM states
//   DEF_NUM_PE        : default number of PE reset outputs
//   DEF_SYNC_STAGES   : default reset synchronizer depth
//   DEF_GAP_CYCLES    : default spacing between releases / soft-reset hold
// -----------------------------------------------------------------------------
package thrive_rst_pkg;

    typedef enum logic [2:0] {
        WAIT_SYNC = 3'd0,
        COUNT     = 3'd1,
        RUN       = 3'd2,
        SOFT_HOLD = 3'd3,
        SOFT_ACK  = 3'd4
    } rst_seq_state_e;

    localparam int DEF_NUM_PE      = 4;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_GAP_CYCLES  = 16;

endpackage

// File: rtl/thrive_pe_rst_seq_if.sv
// -----------------------------------------------------------------------------
// thrive_pe_rst_seq_if
// Bundles the per-PE reset outputs, the soft-reset req/ack handshake and the
// sequencer status flags.
//   soft_rst_req_i : per-PE soft-reset request (level, held until ack)
//   pe_rstn_o      : per-PE active-low reset
//   soft_rst_ack_o : per-PE soft-reset acknowledge
//   seq_done_o     : every PE released at least once since sys_rstn
//   soft_busy_o    : a soft reset is in progress
// Modports: master = requester / reset consumer side, slave = sequencer.
// -----------------------------------------------------------------------------
interface thrive_pe_rst_seq_if #(
    parameter int NUM_PE = 4
);
    logic [NUM_PE-1:0] soft_rst_req_i;
    logic [NUM_PE-1:0] pe_rstn_o;
    logic [NUM_PE-1:0] soft_rst_ack_o;
    logic              seq_done_o;
    logic              soft_busy_o;

    modport master (
        output soft_rst_req_i,
        input  pe_rstn_o,
        input  soft_rst_ack_o,
        input  seq_done_o,
        input  soft_busy_o
    );

    modport slave (
        input  soft_rst_req_i,
        output pe_rstn_o,
        output soft_rst_ack_o,
        output seq_done_o,
        output soft_busy_o
    );
endinterface

// File: rtl/thrive_rst_sync.sv
// -----------------------------------------------------------------------------
// thrive_rst_sync
// Asynchronous-assert / synchronous-deassert reset synchronizer.
//   clk    : destination clock
//   rst_n  : asynchronous active-low reset
//   rst_ok : high once SYNC_STAGES ones have shifted through the chain;
//            rises on edge SYNC_STAGES-1, counting from the first edge that
//            samples rst_n high as edge 0
// -----------------------------------------------------------------------------
module thrive_rst_sync
    import thrive_rst_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    output logic rst_ok
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_ok = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/thrive_pe_rst_seq.sv
// -----------------------------------------------------------------------------
// thrive_pe_rst_seq
// Per-PE reset sequencer. Synchronizes sys_rstn, releases the PE resets in
// index order GAP_CYCLES apart, then serves soft-reset requests one at a time
// (lowest index first) over a 4-phase req/ack handshake.
//   sys_clk  : system clock
//   sys_rstn : asynchronous active-low chip reset
//   rst_bus  : slave side of thrive_pe_rst_seq_if (req in; pe_rstn, ack,
//              seq_done, soft_busy out). Every output is a flop.
// -----------------------------------------------------------------------------
module thrive_pe_rst_seq
    import thrive_rst_pkg::*;
#(
    parameter int NUM_PE      = DEF_NUM_PE,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES
) (
    input  logic                   sys_clk,
    input  logic                   sys_rstn,
    thrive_pe_rst_seq_if.slave     rst_bus
);

    localparam int CNT_W = $clog2(GAP_CYCLES + 1);
    localparam int IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

    rst_seq_state_e    state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [NUM_PE-1:0] pe_rstn_q, pe_rstn_d;
    logic [NUM_PE-1:0] ack_q, ack_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    logic              rst_ok;
    logic              cnt_term;
    logic              req_any;
    logic [IDX_W-1:0]  req_idx;
    logic              req_cur;

    thrive_rst_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (sys_clk),
        .rst_n  (sys_rstn),
        .rst_ok (rst_ok)
    );

    assign cnt_term = (cnt_q == CNT_W'(GAP_CYCLES - 1));
    assign req_any  = |rst_bus.soft_rst_req_i;

    // Lowest-index pending request wins; scanning downward leaves the lowest.
    // req_cur is the request level of the PE currently latched in idx_q.
    always_comb begin
        req_idx = '0;
        req_cur = 1'b0;
        for (int i = NUM_PE - 1; i >= 0; i--) begin
            if (rst_bus.soft_rst_req_i[i]) begin
                req_idx = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_PE; i++) begin
            if (idx_q == IDX_W'(i)) begin
                req_cur = rst_bus.soft_rst_req_i[i];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        pe_rstn_d = pe_rstn_q;
        ack_d     = ack_q;
        done_d    = done_q;
        busy_d    = busy_q;

        case (state_q)
            WAIT_SYNC: begin
                if (rst_ok) begin
                    state_d = COUNT;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end

            COUNT: begin
                if (cnt_term) begin
                    cnt_d = '0;
                    for (int i = 0; i < NUM_PE; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            pe_rstn_d[i] = 1'b1;
                        end
                    end
                    if (idx_q == IDX_W'(NUM_PE - 1)) begin
                        done_d  = 1'b1;
                        state_d = RUN;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            RUN: begin
                if (req_any) begin
                    for (int i = 0; i < NUM_PE; i++) begin
                        if (req_idx == IDX_W'(i)) begin
                            pe_rstn_d[i] = 1'b0;
                        end
                    end
                    idx_d   = req_idx;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SOFT_HOLD;
                end
            end

            SOFT_HOLD: begin
                if (cnt_term) begin
                    cnt_d = '0;
                    for (int i = 0; i < NUM_PE; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            pe_rstn_d[i] = 1'b1;
                            ack_d[i]     = 1'b1;
                        end
                    end
                    state_d = SOFT_ACK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            SOFT_ACK: begin
                // A request already dropped during the hold leaves here on
                // the first edge, so its ack is a single-cycle pulse.
                if (!req_cur) begin
                    for (int i = 0; i < NUM_PE; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            ack_d[i] = 1'b0;
                        end
                    end
                    busy_d  = 1'b0;
                    state_d = RUN;
                end
            end

            default: begin
                state_d = WAIT_SYNC;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state_q   <= WAIT_SYNC;
            cnt_q     <= '0;
            idx_q     <= '0;
            pe_rstn_q <= '0;
            ack_q     <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            pe_rstn_q <= pe_rstn_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign rst_bus.pe_rstn_o      = pe_rstn_q;
    assign rst_bus.soft_rst_ack_o = ack_q;
    assign rst_bus.seq_done_o     = done_q;
    assign rst_bus.soft_busy_o    = busy_q;

endmodule

// File: tb/tb_thrive_pe_rst_seq.sv
// -----------------------------------------------------------------------------
// tb_thrive_pe_rst_seq
// Bench for thrive_pe_rst_seq. Two instances: defaults (4 PE, gap 16, sync 2)
// and a minimal one (1 PE, gap 1, sync 2). A time-based model predicts every
// output from the edge count since release and the soft-reset grant history;
// directed literal checks pin the model at hand-computed edges.
// -----------------------------------------------------------------------------
module tb_thrive_pe_rst_seq;

    localparam int S0 = 2;
    localparam int G0 = 16;
    localparam int N0 = 4;
    localparam int S1 = 2;
    localparam int G1 = 1;
    localparam int N1 = 1;

    logic clk;
    logic rstn0;
    logic rstn1;

    int n_cmp;
    int n_bad;

    thrive_pe_rst_seq_if #(.NUM_PE(N0)) bus0 ();
    thrive_pe_rst_seq_if #(.NUM_PE(N1)) bus1 ();

    thrive_pe_rst_seq #(
        .NUM_PE      (N0),
        .SYNC_STAGES (S0),
        .GAP_CYCLES  (G0)
    ) u_dut0 (
        .sys_clk  (clk),
        .sys_rstn (rstn0),
        .rst_bus  (bus0.slave)
    );

    thrive_pe_rst_seq #(
        .NUM_PE      (N1),
        .SYNC_STAGES (S1),
        .GAP_CYCLES  (G1)
    ) u_dut1 (
        .sys_clk  (clk),
        .sys_rstn (rstn1),
        .rst_bus  (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // e     : rising edges since the first edge that saw reset high (-1 in reset)
    // busy  : a soft reset of PE j, granted at edge 'grant', is outstanding
    // ack   : the hold has finished and the ack is being presented
    typedef struct {
        int e;
        bit busy;
        bit ack;
        int j;
        int grant;
    } mstate_t;

    mstate_t m0;
    mstate_t m1;

    function automatic mstate_t model_reset();
        mstate_t m;
        m.e     = -1;
        m.busy  = 1'b0;
        m.ack   = 1'b0;
        m.j     = 0;
        m.grant = 0;
        return m;
    endfunction

    function automatic mstate_t model_step(input mstate_t m_in, input int s, input int g,
                                           input int n, input logic [3:0] req);
        mstate_t m;
        int last;
        int low;
        m    = m_in;
        m.e  = m.e + 1;
        last = s + n * g;
        if (!m.busy) begin
            if (m.e > last && req != 4'b0) begin
                low = 0;
                for (int i = n - 1; i >= 0; i--) if (req[i]) low = i;
                m.busy  = 1'b1;
                m.ack   = 1'b0;
                m.j     = low;
                m.grant = m.e;
            end
        end else if (!m.ack) begin
            if (m.e == m.grant + g) m.ack = 1'b1;
        end else if (!req[m.j]) begin
            m.busy = 1'b0;
            m.ack  = 1'b0;
        end
        return m;
    endfunction

    function automatic logic [3:0] exp_pe(input mstate_t m, input int s, input int g, input int n);
        logic [3:0] v;
        v = 4'b0;
        for (int i = 0; i < n; i++) begin
            v[i] = (m.e >= s + (i + 1) * g) && !(m.busy && !m.ack && m.j == i);
        end
        return v;
    endfunction

    function automatic logic [3:0] exp_ack(input mstate_t m);
        logic [3:0] v;
        v = 4'b0;
        if (m.busy && m.ack) v[m.j] = 1'b1;
        return v;
    endfunction

    always @(posedge clk or negedge rstn0) begin
        if (!rstn0) m0 = model_reset();
        else        m0 = model_step(m0, S0, G0, N0, bus0.soft_rst_req_i);
    end

    always @(posedge clk or negedge rstn1) begin
        if (!rstn1) m1 = model_reset();
        else        m1 = model_step(m1, S1, G1, N1, {3'b0, bus1.soft_rst_req_i});
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("m0_pe",   bus0.pe_rstn_o,              exp_pe(m0, S0, G0, N0));
        chk("m0_ack",  bus0.soft_rst_ack_o,         exp_ack(m0));
        chk("m0_done", {3'b0, bus0.seq_done_o},     {3'b0, m0.e >= S0 + N0 * G0});
        chk("m0_busy", {3'b0, bus0.soft_busy_o},    {3'b0, m0.busy});
        chk("m1_pe",   {3'b0, bus1.pe_rstn_o},      exp_pe(m1, S1, G1, N1));
        chk("m1_ack",  {3'b0, bus1.soft_rst_ack_o}, exp_ack(m1));
        chk("m1_done", {3'b0, bus1.seq_done_o},     {3'b0, m1.e >= S1 + N1 * G1});
        chk("m1_busy", {3'b0, bus1.soft_busy_o},    {3'b0, m1.busy});
        // After bring-up, at most one PE may be held in reset at any time.
        if (bus0.seq_done_o) begin
            n_cmp++;
            if ($countones(~bus0.pe_rstn_o) > 1) begin
                n_bad++;
                $display("FAIL one_in_reset @%0t: pe_rstn %b has more than one PE low",
                         $time, bus0.pe_rstn_o);
            end
        end
    end

    // Advance (on negedges) until the given instance has seen edge 'target'.
    task automatic go_edge(input int k, input int target);
        int guard;
        guard = 0;
        while (((k == 0) ? m0.e : m1.e) != target) begin
            @(negedge clk);
            guard++;
            if (guard > 2000) begin
                n_cmp++;
                n_bad++;
                $display("FAIL timeout: edge %0d of instance %0d not reached, required %0d",
                         (k == 0) ? m0.e : m1.e, k, target);
                break;
            end
        end
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        n_cmp = 0;
        n_bad = 0;
        m0 = model_reset();
        m1 = model_reset();
        rstn0 = 1'b0;
        rstn1 = 1'b0;
        bus0.soft_rst_req_i = '0;
        bus1.soft_rst_req_i = '0;

        repeat (3) @(negedge clk);
        chk("rst_pe",   bus0.pe_rstn_o,           4'b0000);
        chk("rst_ack",  bus0.soft_rst_ack_o,      4'b0000);
        chk("rst_done", {3'b0, bus0.seq_done_o},  4'b0000);
        chk("rst_busy", {3'b0, bus0.soft_busy_o}, 4'b0000);

        // Bring-up, interrupted by a reset at edge 40.
        rstn0 = 1'b1;
        go_edge(0, 17); chk("e17_pe", bus0.pe_rstn_o, 4'b0000);
        go_edge(0, 18); chk("e18_pe", bus0.pe_rstn_o, 4'b0001);
        go_edge(0, 34); chk("e34_pe", bus0.pe_rstn_o, 4'b0011);
        go_edge(0, 40); chk("e40_pe", bus0.pe_rstn_o, 4'b0011);
        #1 rstn0 = 1'b0;
        #1;
        chk("async_pe",   bus0.pe_rstn_o,          4'b0000);
        chk("async_done", {3'b0, bus0.seq_done_o}, 4'b0000);
        repeat (2) @(negedge clk);

        // Full bring-up, with a request raised during COUNT.
        rstn0 = 1'b1;
        go_edge(0, 17); chk("r17_pe", bus0.pe_rstn_o, 4'b0000);
        go_edge(0, 18); chk("r18_pe", bus0.pe_rstn_o, 4'b0001);
        go_edge(0, 20); bus0.soft_rst_req_i = 4'b0001;
        go_edge(0, 50); chk("r50_pe", bus0.pe_rstn_o, 4'b0111);
                        chk("r50_busy", {3'b0, bus0.soft_busy_o}, 4'b0000);
        go_edge(0, 65); chk("r65_done", {3'b0, bus0.seq_done_o}, 4'b0000);
        go_edge(0, 66); chk("r66_pe", bus0.pe_rstn_o, 4'b1111);
                        chk("r66_done", {3'b0, bus0.seq_done_o}, 4'b0001);
        go_edge(0, 67); chk("r67_pe", bus0.pe_rstn_o, 4'b1110);
                        chk("r67_busy", {3'b0, bus0.soft_busy_o}, 4'b0001);
        go_edge(0, 82); chk("r82_pe", bus0.pe_rstn_o, 4'b1110);
        go_edge(0, 83); chk("r83_pe", bus0.pe_rstn_o, 4'b1111);
                        chk("r83_ack", bus0.soft_rst_ack_o, 4'b0001);
        go_edge(0, 85); chk("r85_ack", bus0.soft_rst_ack_o, 4'b0001);
                        bus0.soft_rst_req_i = 4'b0000;
        go_edge(0, 86); chk("r86_ack", bus0.soft_rst_ack_o, 4'b0000);
                        chk("r86_busy", {3'b0, bus0.soft_busy_o}, 4'b0000);

        // Single request on PE2.
        go_edge(0, 87);  bus0.soft_rst_req_i = 4'b0100;
        go_edge(0, 88);  chk("p2_start", bus0.pe_rstn_o, 4'b1011);
        go_edge(0, 103); chk("p2_hold",  bus0.pe_rstn_o, 4'b1011);
        go_edge(0, 104); chk("p2_rel",   bus0.pe_rstn_o, 4'b1111);
                         chk("p2_ack",   bus0.soft_rst_ack_o, 4'b0100);
                         bus0.soft_rst_req_i = 4'b0000;
        go_edge(0, 105); chk("p2_ackl",  bus0.soft_rst_ack_o, 4'b0000);
                         chk("p2_busy",  {3'b0, bus0.soft_busy_o}, 4'b0000);

        // Simultaneous PE1 and PE3 requests.
        go_edge(0, 106); bus0.soft_rst_req_i = 4'b1010;
        go_edge(0, 107); chk("p13_first", bus0.pe_rstn_o, 4'b1101);
        go_edge(0, 123); chk("p1_rel",    bus0.pe_rstn_o, 4'b1111);
                         chk("p1_ack",    bus0.soft_rst_ack_o, 4'b0010);
        go_edge(0, 124); bus0.soft_rst_req_i = 4'b1000;
        go_edge(0, 125); chk("p1_ackl",   bus0.soft_rst_ack_o, 4'b0000);
                         chk("p1_idle",   bus0.pe_rstn_o, 4'b1111);
        go_edge(0, 126); chk("p3_start",  bus0.pe_rstn_o, 4'b0111);
        go_edge(0, 142); chk("p3_rel",    bus0.pe_rstn_o, 4'b1111);
                         chk("p3_ack",    bus0.soft_rst_ack_o, 4'b1000);
                         bus0.soft_rst_req_i = 4'b0000;
        go_edge(0, 143); chk("p3_ackl",   bus0.soft_rst_ack_o, 4'b0000);

        // Request dropped before ack: still completed, ack pulses once.
        go_edge(0, 145); bus0.soft_rst_req_i = 4'b0001;
        go_edge(0, 146); chk("drop_start", bus0.pe_rstn_o, 4'b1110);
                         bus0.soft_rst_req_i = 4'b0000;
        go_edge(0, 161); chk("drop_hold",  bus0.pe_rstn_o, 4'b1110);
        go_edge(0, 162); chk("drop_rel",   bus0.pe_rstn_o, 4'b1111);
                         chk("drop_ack",   bus0.soft_rst_ack_o, 4'b0001);
        go_edge(0, 163); chk("drop_ackl",  bus0.soft_rst_ack_o, 4'b0000);
                         chk("drop_busy",  {3'b0, bus0.soft_busy_o}, 4'b0000);
                         chk("drop_done",  {3'b0, bus0.seq_done_o}, 4'b0001);

        // Minimal instance: 1 PE, gap 1.
        rstn1 = 1'b1;
        go_edge(1, 2); chk("min_e2_pe",   {3'b0, bus1.pe_rstn_o},  4'b0000);
        go_edge(1, 3); chk("min_e3_pe",   {3'b0, bus1.pe_rstn_o},  4'b0001);
                       chk("min_e3_done", {3'b0, bus1.seq_done_o}, 4'b0001);
        go_edge(1, 5); bus1.soft_rst_req_i = 1'b1;
        go_edge(1, 6); chk("min_soft_pe",   {3'b0, bus1.pe_rstn_o},  4'b0000);
                       chk("min_soft_busy", {3'b0, bus1.soft_busy_o}, 4'b0001);
        go_edge(1, 7); chk("min_rel_pe",  {3'b0, bus1.pe_rstn_o},     4'b0001);
                       chk("min_ack",     {3'b0, bus1.soft_rst_ack_o}, 4'b0001);
                       bus1.soft_rst_req_i = 1'b0;
        go_edge(1, 8); chk("min_ackl",    {3'b0, bus1.soft_rst_ack_o}, 4'b0000);
                       chk("min_busyl",   {3'b0, bus1.soft_busy_o},    4'b0000);

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
